snake_move_ctrl: RTL and testbench

Sequences the snake's movement on a cell grid for the VGA game path. Latches the latest direction button. On each move tick it computes the next head cell, checks it for wall and self collision, then shifts the body array. Exposes a registered read port so the pixel renderer can fetch segment coordinates, plus head, length, direction and game-over status.

---
 rtl/snake_move_ctrl.sv | 263 ++++++++++++++++++++++++++
 tb/tb_snake_move_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_move_ctrl.sv
// Snake movement sequencer: direction latch, wall and self-collision scan, body shift, registered segment read port.
// iTick-to-oMoved latency is 3 + scan limit cycles; an iTick arriving while oBusy is dropped, not queued.
module snake_move_ctrl #(
   parameter int GRID_W    = 64,
   parameter int GRID_H    = 48,
   parameter int MAX_LEN   = 32,
   parameter int START_X   = 32,
   parameter int START_Y   = 24,
   parameter int START_LEN = 4
) (
   input  logic                       iCLK,
   input  logic                       iRST_N,
   input  logic                       iTick,
   input  logic                       iUpButton,
   input  logic                       iDownButton,
   input  logic                       iLeftButton,
   input  logic                       iRightButton,
   input  logic                       iGrow,
   input  logic                       iRestart,
   input  logic [$clog2(MAX_LEN)-1:0] iRd_Idx,
   output logic [5:0]                 oRd_X,
   output logic [5:0]                 oRd_Y,
   output logic                       oRd_Valid,
   output logic [5:0]                 oHead_X,
   output logic [5:0]                 oHead_Y,
   output logic [$clog2(MAX_LEN):0]   oLength,
   output logic [1:0]                 oDir,
   output logic                       oDead,
   output logic                       oBusy,
   output logic                       oMoved
);

   localparam int AW = $clog2(MAX_LEN);
   localparam int LW = AW + 1;

   localparam logic [1:0] DIR_UP = 2'b11;
   localparam logic [1:0] DIR_DN = 2'b00;
   localparam logic [1:0] DIR_LT = 2'b10;
   localparam logic [1:0] DIR_RT = 2'b01;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_STEP   = 3'd1,
      S_CHECK  = 3'd2,
      S_COMMIT = 3'd3,
      S_DEAD   = 3'd4
   } state_t;

   state_t state_q, state_d;

   logic [5:0]    body_x_q [MAX_LEN];
   logic [5:0]    body_y_q [MAX_LEN];
   logic [5:0]    body_x_d [MAX_LEN];
   logic [5:0]    body_y_d [MAX_LEN];
   logic [LW-1:0] len_q, len_d;
   logic [1:0]    dir_q, dir_d;
   logic [1:0]    req_q, req_d;
   logic [1:0]    ndir_q, ndir_d;
   logic          grow_q, grow_d;
   logic [5:0]    nx_q, nx_d;
   logic [5:0]    ny_q, ny_d;
   logic [AW-1:0] idx_q, idx_d;
   logic          moved_q, moved_d;
   logic [5:0]    rd_x_q, rd_x_d;
   logic [5:0]    rd_y_q, rd_y_d;
   logic          rd_vld_q, rd_vld_d;

   logic [1:0]    cand;
   logic          cand_vld;
   logic [5:0]    step_x, step_y;
   logic          wall;
   logic          growing;
   logic [LW-1:0] limit;
   logic          hit;
   logic          scan_done;

   // Direction request: highest-priority button wins, a reversal onto the neck is ignored.
   always_comb begin
      cand     = req_q;
      cand_vld = 1'b1;
      if (iUpButton)         cand = DIR_UP;
      else if (iDownButton)  cand = DIR_DN;
      else if (iLeftButton)  cand = DIR_LT;
      else if (iRightButton) cand = DIR_RT;
      else                   cand_vld = 1'b0;

      req_d = req_q;
      if (cand_vld && (cand != ~dir_q)) req_d = cand;
      if (iRestart) req_d = DIR_RT;
   end

   always_comb begin
      step_x = body_x_q[0];
      step_y = body_y_q[0];
      wall   = 1'b0;
      case (req_q)
         DIR_UP: begin
            wall   = (body_y_q[0] == 6'd0);
            step_y = body_y_q[0] - 6'd1;
         end
         DIR_DN: begin
            wall   = (body_y_q[0] == 6'(GRID_H - 1));
            step_y = body_y_q[0] + 6'd1;
         end
         DIR_LT: begin
            wall   = (body_x_q[0] == 6'd0);
            step_x = body_x_q[0] - 6'd1;
         end
         default: begin
            wall   = (body_x_q[0] == 6'(GRID_W - 1));
            step_x = body_x_q[0] + 6'd1;
         end
      endcase
   end

   // The tail vacates its cell on a plain move, so it is only scanned when growing.
   always_comb begin
      growing   = grow_q && (len_q < LW'(MAX_LEN));
      limit     = growing ? (len_q - LW'(1)) : (len_q - LW'(2));
      hit       = (body_x_q[idx_q] == nx_q) && (body_y_q[idx_q] == ny_q);
      scan_done = ({1'b0, idx_q} >= limit);
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (iTick) state_d = S_STEP;
         S_STEP: begin
            if (wall)                 state_d = S_DEAD;
            else if (limit == '0)     state_d = S_COMMIT;
            else                      state_d = S_CHECK;
         end
         S_CHECK: begin
            if (hit)                  state_d = S_DEAD;
            else if (scan_done)       state_d = S_COMMIT;
         end
         S_COMMIT: state_d = S_IDLE;
         S_DEAD:   state_d = S_DEAD;
         default:  state_d = S_IDLE;
      endcase
      if (iRestart) state_d = S_IDLE;
   end

   always_comb begin
      oBusy = 1'b0;
      oDead = 1'b0;
      case (state_q)
         S_STEP, S_CHECK, S_COMMIT: oBusy = 1'b1;
         S_DEAD:                    oDead = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      body_x_d = body_x_q;
      body_y_d = body_y_q;
      len_d    = len_q;
      dir_d    = dir_q;
      ndir_d   = ndir_q;
      nx_d     = nx_q;
      ny_d     = ny_q;
      idx_d    = idx_q;
      grow_d   = grow_q;
      moved_d  = (state_q == S_COMMIT);

      case (state_q)
         S_STEP: begin
            nx_d   = step_x;
            ny_d   = step_y;
            ndir_d = req_q;
            idx_d  = AW'(1);
         end
         S_CHECK: idx_d = idx_q + AW'(1);
         S_COMMIT: begin
            for (int i = 1; i < MAX_LEN; i++) begin
               body_x_d[i] = body_x_q[i-1];
               body_y_d[i] = body_y_q[i-1];
            end
            body_x_d[0] = nx_q;
            body_y_d[0] = ny_q;
            dir_d       = ndir_q;
            if (growing) len_d = len_q + LW'(1);
            grow_d      = 1'b0;
         end
         default: ;
      endcase

      if (iGrow) grow_d = 1'b1;

      if (iRestart) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            body_x_d[i] = 6'(START_X - i);
            body_y_d[i] = 6'(START_Y);
         end
         len_d   = LW'(START_LEN);
         dir_d   = DIR_RT;
         ndir_d  = DIR_RT;
         nx_d    = '0;
         ny_d    = '0;
         idx_d   = '0;
         grow_d  = 1'b0;
         moved_d = 1'b0;
      end
   end

   // Read port samples the array before this edge's update, independent of restart.
   always_comb begin
      rd_x_d   = body_x_q[iRd_Idx];
      rd_y_d   = body_y_q[iRd_Idx];
      rd_vld_d = ({1'b0, iRd_Idx} < len_q);
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            body_x_q[i] <= 6'(START_X - i);
            body_y_q[i] <= 6'(START_Y);
         end
         len_q    <= LW'(START_LEN);
         dir_q    <= DIR_RT;
         req_q    <= DIR_RT;
         ndir_q   <= DIR_RT;
         grow_q   <= 1'b0;
         nx_q     <= '0;
         ny_q     <= '0;
         idx_q    <= '0;
         moved_q  <= 1'b0;
         rd_x_q   <= '0;
         rd_y_q   <= '0;
         rd_vld_q <= 1'b0;
      end else begin
         body_x_q <= body_x_d;
         body_y_q <= body_y_d;
         len_q    <= len_d;
         dir_q    <= dir_d;
         req_q    <= req_d;
         ndir_q   <= ndir_d;
         grow_q   <= grow_d;
         nx_q     <= nx_d;
         ny_q     <= ny_d;
         idx_q    <= idx_d;
         moved_q  <= moved_d;
         rd_x_q   <= rd_x_d;
         rd_y_q   <= rd_y_d;
         rd_vld_q <= rd_vld_d;
      end
   end

   assign oRd_X     = rd_x_q;
   assign oRd_Y     = rd_y_q;
   assign oRd_Valid = rd_vld_q;
   assign oHead_X   = body_x_q[0];
   assign oHead_Y   = body_y_q[0];
   assign oLength   = len_q;
   assign oDir      = dir_q;
   assign oMoved    = moved_q;

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Bench for snake_move_ctrl: directed game scenarios then random play, checked against a move-level model.
module tb_snake_move_ctrl;

   localparam int MAX_LEN = 32;
   localparam int GW      = 64;
   localparam int GH      = 48;

   logic       iCLK = 1'b0;
   logic       iRST_N = 1'b0;
   logic       iTick = 1'b0;
   logic       iUpButton = 1'b0, iDownButton = 1'b0, iLeftButton = 1'b0, iRightButton = 1'b0;
   logic       iGrow = 1'b0;
   logic       iRestart = 1'b0;
   logic [4:0] iRd_Idx = '0;
   logic [5:0] oRd_X, oRd_Y, oHead_X, oHead_Y;
   logic       oRd_Valid, oDead, oBusy, oMoved;
   logic [5:0] oLength;
   logic [1:0] oDir;

   snake_move_ctrl #(
      .GRID_W(64), .GRID_H(48), .MAX_LEN(32), .START_X(32), .START_Y(24), .START_LEN(4)
   ) dut (
      .iCLK(iCLK), .iRST_N(iRST_N), .iTick(iTick),
      .iUpButton(iUpButton), .iDownButton(iDownButton),
      .iLeftButton(iLeftButton), .iRightButton(iRightButton),
      .iGrow(iGrow), .iRestart(iRestart), .iRd_Idx(iRd_Idx),
      .oRd_X(oRd_X), .oRd_Y(oRd_Y), .oRd_Valid(oRd_Valid),
      .oHead_X(oHead_X), .oHead_Y(oHead_Y), .oLength(oLength),
      .oDir(oDir), .oDead(oDead), .oBusy(oBusy), .oMoved(oMoved)
   );

   always #5 iCLK = ~iCLK;

   int total = 0;
   int bad   = 0;

   // Game model: whole body array (stale entries included), length, directions, flags.
   int mx [MAX_LEN];
   int my [MAX_LEN];
   int mlen, mdir, mreq;
   bit mgrow, mdead;

   localparam logic [3:0] B_NONE = 4'b0000, B_UP = 4'b1000, B_DN = 4'b0100,
                          B_LT = 4'b0010, B_RT = 4'b0001;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < MAX_LEN; i++) begin
         mx[i] = 32 - i;
         my[i] = 24;
      end
      mlen = 4; mdir = 1; mreq = 1; mgrow = 0; mdead = 0;
   endtask

   task automatic model_buttons(input logic [3:0] b);
      int cand;
      cand = -1;
      if (b[3])      cand = 3;
      else if (b[2]) cand = 0;
      else if (b[1]) cand = 2;
      else if (b[0]) cand = 1;
      if (cand >= 0 && cand != (mdir ^ 3)) mreq = cand;
   endtask

   task automatic check_status(input string tag);
      chk({tag, ".head_x"}, oHead_X, mx[0]);
      chk({tag, ".head_y"}, oHead_Y, my[0]);
      chk({tag, ".len"},    oLength, mlen);
      chk({tag, ".dir"},    oDir,    mdir);
      chk({tag, ".dead"},   oDead,   mdead);
      chk({tag, ".busy"},   oBusy,   0);
   endtask

   task automatic do_move(input logic [3:0] btn, input bit grow, output int lat);
      int nx, ny, lim, moved_cnt, budget;
      bit wall, hit, growing, exp_dead, was_dead;
      @(negedge iCLK);
      {iUpButton, iDownButton, iLeftButton, iRightButton} = btn;
      iGrow = grow;
      @(negedge iCLK);
      {iUpButton, iDownButton, iLeftButton, iRightButton} = 4'b0;
      iGrow = 1'b0;
      model_buttons(btn);
      if (grow) mgrow = 1;

      was_dead = mdead;
      exp_dead = mdead;
      growing  = 0;
      lim      = 0;
      nx       = mx[0];
      ny       = my[0];
      if (!mdead) begin
         case (mreq)
            3: ny = ny - 1;
            0: ny = ny + 1;
            2: nx = nx - 1;
            default: nx = nx + 1;
         endcase
         wall    = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
         growing = mgrow && (mlen < MAX_LEN);
         lim     = growing ? mlen - 1 : mlen - 2;
         hit     = 0;
         if (!wall)
            for (int k = 1; k <= lim; k++)
               if (mx[k] == nx && my[k] == ny) hit = 1;
         exp_dead = wall || hit;
      end

      iTick     = 1'b1;
      lat       = -1;
      moved_cnt = 0;
      budget    = was_dead ? 10 : 60;
      for (int c = 1; c <= budget; c++) begin
         @(negedge iCLK);
         iTick = 1'b0;
         if (oMoved === 1'b1) begin
            moved_cnt++;
            if (lat < 0) lat = c;
         end
         if (!was_dead && (oMoved === 1'b1 || oDead === 1'b1)) break;
      end

      if (!was_dead) begin
         if (exp_dead) mdead = 1;
         else begin
            for (int k = MAX_LEN - 1; k >= 1; k--) begin
               mx[k] = mx[k-1];
               my[k] = my[k-1];
            end
            mx[0] = nx; my[0] = ny;
            mdir  = mreq;
            if (growing) mlen++;
            mgrow = 0;
         end
      end

      chk("move.moved_pulses", moved_cnt, exp_dead ? 0 : 1);
      if (!exp_dead) chk("move.latency", lat, 3 + lim);
      check_status("move");
   endtask

   task automatic read_chk(input int k);
      @(negedge iCLK);
      iRd_Idx = 5'(k);
      @(negedge iCLK);
      chk("rd.x",     oRd_X,     mx[k] & 63);
      chk("rd.y",     oRd_Y,     my[k] & 63);
      chk("rd.valid", oRd_Valid, k < mlen);
   endtask

   task automatic restart();
      @(negedge iCLK);
      iRestart = 1'b1;
      @(negedge iCLK);
      iRestart = 1'b0;
      model_reset();
      check_status("restart");
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      logic [3:0] btn;

      model_reset();
      repeat (2) @(negedge iCLK);
      chk("reset.moved",  oMoved,    0);
      chk("reset.rd_x",   oRd_X,     0);
      chk("reset.rd_y",   oRd_Y,     0);
      chk("reset.rd_vld", oRd_Valid, 0);
      check_status("reset");
      iRST_N = 1'b1;
      @(negedge iCLK);

      // First move, no buttons.
      do_move(B_NONE, 0, lat);
      chk("first.latency", lat, 5);
      chk("first.head_x", oHead_X, 33);
      read_chk(3);
      chk("first.seg3_x", oRd_X, 30);

      // Reverse request ignored, then turn up.
      do_move(B_LT, 0, lat);
      chk("left_ignored.dir", oDir, 2'b01);
      do_move(B_UP, 0, lat);
      chk("up.dir", oDir, 2'b11);
      chk("up.head_y", oHead_Y, 23);

      // Grow once.
      do_move(B_NONE, 1, lat);
      chk("grow.latency", lat, 6);
      chk("grow.len", oLength, 5);
      read_chk(4);

      // Grow to saturation moving right, then hit the east wall.
      restart();
      for (int i = 0; i < 29; i++) do_move(B_RT, 1, lat);
      chk("sat.len", oLength, 32);
      for (int i = 0; i < 2; i++) do_move(B_NONE, 0, lat);
      chk("wall.pre_x", oHead_X, 63);
      do_move(B_NONE, 0, lat);
      chk("wall.dead", oDead, 1);
      do_move(B_NONE, 0, lat);
      chk("wall.frozen_x", oHead_X, 63);
      chk("wall.frozen_y", oHead_Y, 24);
      read_chk(31);

      // Self hit with length 5.
      restart();
      do_move(B_NONE, 1, lat);
      do_move(B_UP, 0, lat);
      do_move(B_LT, 0, lat);
      do_move(B_DN, 0, lat);
      chk("self.dead", oDead, 1);

      // Tail chase around a 2x2 loop survives.
      restart();
      for (int r = 0; r < 2; r++) begin
         do_move(B_UP, 0, lat);
         do_move(B_LT, 0, lat);
         do_move(B_DN, 0, lat);
         do_move(B_RT, 0, lat);
      end
      chk("chase.alive", oDead, 0);

      // Restart mid-scan, colliding with a tick.
      restart();
      @(negedge iCLK); iTick = 1'b1;
      @(negedge iCLK); iTick = 1'b0;
      @(negedge iCLK);
      chk("midscan.busy", oBusy, 1);
      iRestart = 1'b1; iTick = 1'b1;
      @(negedge iCLK);
      iRestart = 1'b0; iTick = 1'b0;
      model_reset();
      check_status("midscan");
      @(negedge iCLK);
      chk("midscan.tick_dropped", oBusy, 0);
      read_chk(2);
      read_chk(7);

      // Random play.
      restart();
      for (int n = 0; n < 250; n++) begin
         btn = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : B_NONE;
         do_move(btn, $urandom_range(0, 5) == 0, lat);
         if ($urandom_range(0, 3) == 0) read_chk($urandom_range(0, MAX_LEN - 1));
         if (mdead) begin
            do_move(4'($urandom_range(0, 15)), 0, lat);
            read_chk(mlen - 1);
            restart();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
